// File: rtl/ram_dumper.sv
// rtl/ram_dumper.sv - streams a RAM window byte-by-byte to a UART transmitter.
// Optional trailing 8-bit checksum byte when DUMP_CHECKSUM_EN is defined.
module ram_dumper #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       length,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_data,
   output logic [7:0]        tx_data,
   output logic              transmit,
   input  logic              tx_done,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_SEND   = 3'd3,
      S_WAIT   = 3'd4,
`ifdef DUMP_CHECKSUM_EN
      S_CSUM   = 3'd5,
`endif
      S_FINISH = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_tx_data;
   logic [15:0]       r_remaining;
   logic              r_done;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]        r_csum;
   // Set once the data bytes are exhausted: LATCH/SEND/WAIT then carry the checksum byte.
   logic              r_csum_phase;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (length != 16'd0) ? S_FETCH : S_FINISH;
            end
         end
         S_FETCH: w_next = S_LATCH;
         S_LATCH: w_next = S_SEND;
         S_SEND:  w_next = S_WAIT;
         S_WAIT: begin
            if (tx_done) begin
`ifdef DUMP_CHECKSUM_EN
               if (r_csum_phase) begin
                  w_next = S_FINISH;
               end else if (r_remaining != 16'd1) begin
                  w_next = S_FETCH;
               end else begin
                  w_next = S_CSUM;
               end
`else
               w_next = (r_remaining != 16'd1) ? S_FETCH : S_FINISH;
`endif
            end
         end
`ifdef DUMP_CHECKSUM_EN
         // CSUM occupies the FETCH slot so the checksum byte keeps the same latency.
         S_CSUM:  w_next = S_LATCH;
`endif
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      transmit = (r_state == S_SEND);
      busy     = (r_state != S_IDLE);
      done     = r_done;
      ram_addr = r_addr;
      tx_data  = r_tx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr      <= '0;
         r_tx_data   <= 8'h00;
         r_remaining <= 16'd0;
         r_done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         r_csum       <= 8'h00;
         r_csum_phase <= 1'b0;
`endif
      end else begin
         r_done <= (r_state == S_FINISH);
         case (r_state)
            S_IDLE: begin
               if (start && length != 16'd0) begin
                  r_addr      <= base_addr;
                  r_remaining <= length;
`ifdef DUMP_CHECKSUM_EN
                  r_csum       <= 8'h00;
                  r_csum_phase <= 1'b0;
`endif
               end
            end
            S_LATCH: begin
`ifdef DUMP_CHECKSUM_EN
               if (r_csum_phase) begin
                  r_tx_data <= r_csum;
               end else begin
                  r_tx_data <= ram_data;
                  r_csum    <= r_csum + ram_data;
               end
`else
               r_tx_data <= ram_data;
`endif
            end
            S_WAIT: begin
`ifdef DUMP_CHECKSUM_EN
               if (tx_done && !r_csum_phase) begin
`else
               if (tx_done) begin
`endif
                  r_remaining <= r_remaining - 16'd1;
                  r_addr      <= r_addr + ADDR_W'(1);
               end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: r_csum_phase <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_dumper.sv
// tb/tb_ram_dumper.sv - directed self-checking bench for ram_dumper.
module tb_ram_dumper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = 16'h0000;
   logic [15:0] length = 16'h0000;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data;
   logic [7:0]  tx_data;
   logic        transmit;
   logic        tx_done = 1'b0;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:65535];
   logic [7:0]  got[$];
   logic [15:0] got_addr[$];

   int checks = 0;
   int failures = 0;
   int first_tx_n, gap_n, done_n, busy_cyc, stall_bad, last_ack_n;
   int nb4, nb2, nb1;

   ram_dumper #(.ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .ram_addr(ram_addr), .ram_data(ram_data), .tx_data(tx_data), .transmit(transmit),
      .tx_done(tx_done), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ram_data <= mem[ram_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_check(input int ncyc, input string tag);
      int cnt;
      cnt = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (transmit) cnt++;
      end
      chk(tag, cnt, 0);
   endtask

   task automatic run(input logic [15:0] b, input logic [15:0] l, input int ack_delay,
                      input int abort_at, input bit spur_start, input int max_cyc);
      int n, ack;
      bit done_seen;
      logic [15:0] hold_addr;
      logic [7:0]  hold_data;
      got.delete(); got_addr.delete();
      first_tx_n = -1; gap_n = -1; done_n = -1; busy_cyc = 0; stall_bad = 0; last_ack_n = -1;
      hold_addr = '0; hold_data = '0; done_seen = 0;
      @(negedge clk); base_addr = b; length = l; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0; ack = -1;
      while (n < max_cyc) begin
         tx_done = 1'b0; start = 1'b0;
         busy_cyc += int'(busy);
         if (done) begin done_n = n; done_seen = 1; break; end
         if (transmit) begin
            if (first_tx_n < 0) first_tx_n = n;
            else if (gap_n < 0 && last_ack_n >= 0) gap_n = n - last_ack_n;
            got.push_back(tx_data); got_addr.push_back(ram_addr);
            hold_addr = ram_addr; hold_data = tx_data;
            ack = ack_delay;
         end else if (ack > 0) begin
            if (ram_addr !== hold_addr || tx_data !== hold_data) stall_bad++;
         end
         if (abort_at != 0 && got.size() == abort_at && !transmit) begin
            #2 rst = 1'b1;
            #1;
            chk("abort_transmit", transmit, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_addr", ram_addr, 16'h0000);
            break;
         end
         if (spur_start && ack == 5) begin start = 1'b1; base_addr = 16'h3000; length = 16'd9; end
         if (ack > 0) begin
            ack--;
            if (ack == 0) begin tx_done = 1'b1; last_ack_n = n; end
         end
         @(negedge clk); n++;
      end
      tx_done = 1'b0; start = 1'b0;
      if (abort_at == 0) chk("done_seen", done_seen, 1);
   endtask

   initial begin
`ifdef DUMP_CHECKSUM_EN
      nb4 = 5; nb2 = 3; nb1 = 2;
`else
      nb4 = 4; nb2 = 2; nb1 = 1;
`endif
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h02; mem[16'h0012] = 8'h03; mem[16'h0013] = 8'hFF;
      mem[16'hFFFF] = 8'h7E; mem[16'h0000] = 8'h81; mem[16'h0020] = 8'h5A;

      // Reset is asserted from time 0, before any clock edge.
      #1;
      chk("rst_ram_addr", ram_addr, 16'h0000);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_transmit", transmit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_check(20, "post_reset_no_tx");

      // Basic dump.
      run(16'h0010, 16'd4, 10, 0, 0, 500);
      chk("basic_count", got.size(), nb4);
      if (got.size() >= 4) begin
         chk("basic_b0", got[0], 8'h01);
         chk("basic_b1", got[1], 8'h02);
         chk("basic_b2", got[2], 8'h03);
         chk("basic_b3", got[3], 8'hFF);
         chk("basic_addr3", got_addr[3], 16'h0013);
      end
`ifdef DUMP_CHECKSUM_EN
      if (got.size() >= 5) chk("basic_csum", got[4], 8'h05);
`endif
      chk("first_latency", first_tx_n, 2);
      chk("next_latency", gap_n, 3);
      chk("basic_end_addr", ram_addr, 16'h0014);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("basic_idle_busy", busy, 0);

      // Spurious tx_done in IDLE.
      repeat (5) begin @(negedge clk); tx_done = 1'b1; end
      @(negedge clk); tx_done = 1'b0;
      chk("idle_txdone_addr", ram_addr, 16'h0014);
      idle_check(5, "idle_txdone_no_tx");

      // start pulse while busy must be ignored.
      run(16'h0010, 16'd4, 10, 0, 1, 500);
      chk("spur_count", got.size(), nb4);
      if (got.size() >= 4) begin
         chk("spur_addr0", got_addr[0], 16'h0010);
         chk("spur_addr3", got_addr[3], 16'h0013);
      end
      chk("spur_end_addr", ram_addr, 16'h0014);
      idle_check(20, "spur_no_extra_tx");

      // Zero length.
      run(16'h0040, 16'd0, 10, 0, 0, 50);
      chk("zero_count", got.size(), 0);
      chk("zero_done_at", done_n, 1);
      chk("zero_busy_cycles", busy_cyc, 1);
      chk("zero_addr_kept", ram_addr, 16'h0014);

      // Address wrap.
      run(16'hFFFF, 16'd2, 10, 0, 0, 500);
      chk("wrap_count", got.size(), nb2);
      if (got.size() >= 2) begin
         chk("wrap_addr0", got_addr[0], 16'hFFFF);
         chk("wrap_addr1", got_addr[1], 16'h0000);
         chk("wrap_b0", got[0], 8'h7E);
         chk("wrap_b1", got[1], 8'h81);
      end
      chk("wrap_end_addr", ram_addr, 16'h0001);

      // Reset while waiting on byte 2 of 4.
      run(16'h0010, 16'd4, 10, 2, 0, 500);
      chk("abort_sent", got.size(), 2);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_check(30, "abort_no_more_tx");
      run(16'h0010, 16'd4, 10, 0, 0, 500);
      chk("restart_count", got.size(), nb4);
      if (got.size() >= 1) begin
         chk("restart_addr0", got_addr[0], 16'h0010);
         chk("restart_b0", got[0], 8'h01);
      end

      // Long stall in WAIT.
      run(16'h0020, 16'd1, 1000, 0, 0, 1500);
      chk("stall_count", got.size(), nb1);
      if (got.size() >= 1) chk("stall_b0", got[0], 8'h5A);
      chk("stall_stable", stall_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
